// File: rtl/memory_score_ctrl.sv
// Turn, score and winner controller for the memory-card game; match/miss pulses two edges after the second pick.
// No backpressure: picks arriving outside PICK1/PICK2 (busy or finished) are dropped, never queued.
module memory_score_ctrl #(
  parameter int N_PLAYERS = 2,
  parameter int N_PAIRS   = 8,
  parameter int CARD_W    = 4,
  parameter int ADDR_W    = 4,
  localparam int PW       = (N_PLAYERS > 2) ? $clog2(N_PLAYERS) : 1,
  localparam int SW       = $clog2(N_PAIRS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    new_game,
  input  logic                    select,
  input  logic [ADDR_W-1:0]       card_addr,
  input  logic [CARD_W-1:0]       card_value,
  input  logic                    card_valid,
  output logic [PW-1:0]           player,
  output logic [N_PLAYERS*SW-1:0] scores,
  output logic [ADDR_W-1:0]       first_addr,
  output logic [ADDR_W-1:0]       second_addr,
  output logic                    match,
  output logic                    miss,
  output logic                    busy,
  output logic                    game_over,
  output logic [PW-1:0]           winner,
  output logic                    tie
);

  typedef enum logic [2:0] {
    PICK1,
    PICK2,
    COMPARE,
    RESOLVE,
    DONE
  } state_t;

  state_t             state;
  logic [CARD_W-1:0]  v1;
  logic [CARD_W-1:0]  v2;
  logic               eq;
  logic [SW-1:0]      pair_cnt;
  logic [SW-1:0]      score_q  [N_PLAYERS];
  logic [SW-1:0]      score_nx [N_PLAYERS];
  logic [SW-1:0]      best;
  logic [PW-1:0]      winner_nx;
  logic               tie_nx;
  logic [PW-1:0]      player_inc;

  // Winner and tie look at the post-RESOLVE scores so they can be registered
  // in the same edge that delivers the final match pulse.
  always_comb begin
    for (int k = 0; k < N_PLAYERS; k++) begin
      score_nx[k] = score_q[k];
      if (state == RESOLVE && eq && PW'(k) == player) begin
        score_nx[k] = score_q[k] + SW'(1);
      end
    end
    best      = score_nx[0];
    winner_nx = '0;
    for (int k = 1; k < N_PLAYERS; k++) begin
      if (score_nx[k] > best) begin
        best      = score_nx[k];
        winner_nx = PW'(k);
      end
    end
    tie_nx = 1'b0;
    for (int k = 0; k < N_PLAYERS; k++) begin
      if (score_nx[k] == best && PW'(k) != winner_nx) begin
        tie_nx = 1'b1;
      end
    end
  end

  assign player_inc = (player == PW'(N_PLAYERS - 1)) ? '0 : player + PW'(1);

  for (genvar k = 0; k < N_PLAYERS; k++) begin : g_scores
    assign scores[k*SW +: SW] = score_q[k];
  end

  always_ff @(posedge clk) begin
    if (rst || new_game) begin
      state       <= PICK1;
      player      <= '0;
      pair_cnt    <= '0;
      first_addr  <= '0;
      second_addr <= '0;
      v1          <= '0;
      v2          <= '0;
      eq          <= 1'b0;
      match       <= 1'b0;
      miss        <= 1'b0;
      busy        <= 1'b0;
      game_over   <= 1'b0;
      winner      <= '0;
      tie         <= 1'b0;
      for (int k = 0; k < N_PLAYERS; k++) begin
        score_q[k] <= '0;
      end
    end else begin
      match <= 1'b0;
      miss  <= 1'b0;
      case (state)
        PICK1: begin
          if (select && card_valid) begin
            first_addr <= card_addr;
            v1         <= card_value;
            state      <= PICK2;
          end
        end
        PICK2: begin
          if (select && card_valid && card_addr != first_addr) begin
            second_addr <= card_addr;
            v2          <= card_value;
            busy        <= 1'b1;
            state       <= COMPARE;
          end
        end
        COMPARE: begin
          eq    <= (v1 == v2);
          state <= RESOLVE;
        end
        RESOLVE: begin
          busy <= 1'b0;
          for (int k = 0; k < N_PLAYERS; k++) begin
            score_q[k] <= score_nx[k];
          end
          if (eq) begin
            match    <= 1'b1;
            pair_cnt <= pair_cnt + SW'(1);
            if (pair_cnt == SW'(N_PAIRS - 1)) begin
              game_over <= 1'b1;
              winner    <= winner_nx;
              tie       <= tie_nx;
              state     <= DONE;
            end else begin
              state <= PICK1;
            end
          end else begin
            miss   <= 1'b1;
            player <= player_inc;
            state  <= PICK1;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= PICK1;
        end
      endcase
    end
  end

endmodule

// File: doc/memory_score_ctrl.md
# memory_score_ctrl

Parametrised turn, score and winner controller for the memory-card game. Sits between the board/card-store logic and the display, and replaces the fixed two-player, eight-pair turn tracker. It accepts card picks and compares each pair of picks. It keeps one score per player, passes the turn on a miss, keeps the turn on a match, and declares the winner or a tie when every pair is matched.

## Interface
Parameters:
- N_PLAYERS, default 2: number of players, 2..8.
- N_PAIRS, default 8: pairs on the board, 1..32.
- CARD_W, default 4: card face value width.
- ADDR_W, default 4: board slot address width.
- Derived: PW = max(1, $clog2(N_PLAYERS)); SW = $clog2(N_PAIRS+1).

Ports:
- clk, input, 1: single clock. All logic is on the rising edge.
- rst, input, 1: reset, synchronous, active-high.
- new_game, input, 1: one-cycle request to clear the game. Same effect as rst on all state.
- select, input, 1: one-cycle pick strobe.
- card_addr, input, ADDR_W: slot being picked. Sampled with select.
- card_value, input, CARD_W: face value of that slot. Sampled with select.
- card_valid, input, 1: slot still holds an unmatched card. Picks with card_valid=0 are ignored.
- player, output, PW: index of the current player.
- scores, output, N_PLAYERS*SW: flattened scores. Player k occupies bits [k*SW +: SW].
- first_addr, output, ADDR_W: registered slot of the first pick.
- second_addr, output, ADDR_W: registered slot of the second pick.
- match, output, 1: one-cycle pulse. The two picks matched; the board removes first_addr and second_addr.
- miss, output, 1: one-cycle pulse. The two picks did not match; the board hides both cards.
- busy, output, 1: high in COMPARE and RESOLVE.
- game_over, output, 1: level. The game is finished.
- winner, output, PW: index of the player with the highest score. Valid while game_over=1.
- tie, output, 1: two or more players share the highest score. Valid while game_over=1.

## Operation
- FSM states: PICK1, PICK2, COMPARE, RESOLVE, DONE. Reset state is PICK1.
- Reset values (rst or new_game):
  - state = PICK1.
  - player, all scores, pair counter, first_addr, second_addr = 0.
  - match, miss, busy, game_over, winner, tie = 0.
- rst has priority over new_game. new_game has priority over select.
- PICK1: on select && card_valid, latch card_addr into first_addr and card_value into v1, then go to PICK2.
- PICK2: on select && card_valid && card_addr != first_addr, latch second_addr and v2, then go to COMPARE.
  - A repeated pick of the same slot is ignored; the state stays in PICK2.
- COMPARE: one cycle. Registers eq = (v1 == v2). Go to RESOLVE.
- RESOLVE: one cycle.
  - If eq: increment scores[player] and the pair counter, and pulse match. The player is unchanged.
  - If not eq: pulse miss, and player becomes (player+1) mod N_PLAYERS. The wrap is from N_PLAYERS-1 to 0, including non-power-of-two counts.
  - Next state is DONE if eq and the pair counter is about to reach N_PAIRS; otherwise PICK1.
- DONE: game_over = 1.
  - winner = lowest index holding the maximum score.
  - tie = 1 if more than one player holds that maximum.
  - Winner and tie are computed combinationally from the scores and registered on entry to DONE.
  - select is ignored. The block stays in DONE until rst or new_game.
- select outside PICK1/PICK2, including while busy, is dropped and not queued.
- Scores cannot exceed N_PAIRS, so SW bits never overflow. There is no saturation logic.

## Timing
- Call the edge that accepts the second pick E.
- State is COMPARE between E and E+1, and RESOLVE between E+1 and E+2.
- Edge E+2: match or miss is registered high, together with the score and player updates. The pulse is visible for exactly one cycle and cleared at E+3.
- State after E+2 is PICK1, or DONE for the last pair. The earliest the next first pick is accepted is E+3.
- game_over, winner and tie rise at E+2, in the same cycle as the final match pulse.
- busy is high from E to E+2.
- new_game in any state: everything is cleared on the next edge. A pulse in flight is cancelled.

## Test plan
- Reset values: hold rst for 2 cycles with select toggling. All outputs are 0, state is PICK1, and no pick is latched.
- Match keeps the turn: N_PLAYERS=3. Pick addr 2 (value 5), then addr 7 (value 5). match pulses one cycle at E+2, scores[0]=1, player stays 0.
- Miss and wrap:
  - Player 2 of 3 picks values 4 and 9. miss pulses, player becomes 0, and scores are unchanged.
  - Same-slot second pick or a card_valid=0 pick: no state change.
- Full game, clear winner: N_PAIRS=8, 2 players, player 0 takes 5 pairs and player 1 takes 3. At the final E+2: game_over=1, winner=0, tie=0. Further selects are ignored.
- Tie: 3 players with final scores 3/3/2. game_over=1, winner=0, tie=1.
- Mid-operation clear:
  - new_game asserted in COMPARE: no match/miss pulse, scores are 0, state is PICK1.
  - rst and new_game asserted together with select: rst wins and nothing is latched.
